// File: rtl/sum4b_pkg.sv
// Shared constants for the registered ripple-carry adder slice.
package sum4b_pkg;

  localparam int SUM4B_WIDTH = 4;

  // Every bit of the result register resets to this value.
  localparam logic RESULT_RST_BIT = 1'b0;

endpackage

// File: rtl/sum4b_if.sv
// Operand/result bundle between the adder and its surrounding datapath.
interface sum4b_if #(
  parameter int WIDTH = sum4b_pkg::SUM4B_WIDTH
);

  logic [WIDTH-1:0] xi;
  logic [WIDTH-1:0] yi;
  logic             in_valid;
  logic [WIDTH-1:0] zi;
  logic             co;
  logic             ovf;
  logic             out_valid;

  modport master (
    output xi, yi, in_valid,
    input  zi, co, ovf, out_valid
  );

  modport slave (
    input  xi, yi, in_valid,
    output zi, co, ovf, out_valid
  );

endinterface

// File: rtl/sum4b_fa.sv
// One-bit full adder cell used to build the ripple carry chain.
module sum4b_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/sum4b_core.sv
// Registered unsigned ripple-carry adder with carry, signed-overflow and valid flags.
module sum4b_core
  import sum4b_pkg::*;
#(
  parameter int WIDTH = SUM4B_WIDTH
) (
  input logic    clk,
  input logic    rst_n,
  sum4b_if.slave bus
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  logic [WIDTH-1:0] zi_q, zi_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    sum4b_fa u_fa (
      .a_i  (bus.xi[i]),
      .b_i  (bus.yi[i]),
      .ci_i (carry_s[i]),
      .s_o  (sum_s[i]),
      .co_o (carry_s[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];

  always_comb begin
    zi_d        = zi_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      zi_d        = sum_s;
      co_d        = carry_s[WIDTH];
      ovf_d       = ovf_s;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zi_q        <= {WIDTH{RESULT_RST_BIT}};
      co_q        <= RESULT_RST_BIT;
      ovf_q       <= RESULT_RST_BIT;
      out_valid_q <= 1'b0;
    end else begin
      zi_q        <= zi_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.zi        = zi_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sum4b_core.sv
// Directed self-checking bench for sum4b_core.
module tb_sum4b_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sum4b_if #(.WIDTH(4)) bus ();

  sum4b_core #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands on the falling edge; outputs settle just after the next rising edge.
  task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic v);
    @(negedge clk);
    bus.xi       = x;
    bus.yi       = y;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.zi, bus.co, bus.ovf, bus.out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_init got=%b want=%b", {bus.zi, bus.co, bus.ovf, bus.out_valid}, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd15, 4'd9, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.out_valid} !== {4'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_prefill got=%b want=%b", {bus.zi, bus.co, bus.out_valid}, {4'd8, 1'b1, 1'b1});
    end
    @(negedge clk);
    bus.xi = 4'd2; bus.yi = 4'd3; bus.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.zi, bus.co, bus.ovf, bus.out_valid} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b", {bus.zi, bus.co, bus.ovf, bus.out_valid}, 7'd0);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_valid got=%b want=0", bus.out_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid got=%b want=0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.zi, bus.co, bus.out_valid} !== {4'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_result got=%b want=%b", {bus.zi, bus.co, bus.out_valid}, {4'd5, 1'b0, 1'b1});
    end
  endtask

  task automatic test_sweep();
    for (int y = 0; y < 15; y++) begin
      logic [3:0] yv;
      logic [3:0] want;
      yv   = 4'(y);
      want = 4'(y + 1);
      apply(4'd1, yv, 1'b1);
      checks++;
      if ({bus.zi, bus.co, bus.out_valid} !== {want, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL sweep y=%0d got zi=%0d co=%b v=%b want zi=%0d co=0 v=1", y, bus.zi, bus.co, bus.out_valid, want);
      end
    end
  endtask

  task automatic test_wrap();
    apply(4'd15, 4'd1, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.ovf} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_15p1 got=%b want=%b", {bus.zi, bus.co, bus.ovf}, {4'd0, 1'b1, 1'b0});
    end
    apply(4'd15, 4'd15, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.ovf} !== {4'd14, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_15p15 got=%b want=%b", {bus.zi, bus.co, bus.ovf}, {4'd14, 1'b1, 1'b0});
    end
  endtask

  task automatic test_overflow();
    apply(4'd7, 4'd1, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.ovf} !== {4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_7p1 got=%b want=%b", {bus.zi, bus.co, bus.ovf}, {4'd8, 1'b0, 1'b1});
    end
    apply(4'd8, 4'd8, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.ovf} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_8p8 got=%b want=%b", {bus.zi, bus.co, bus.ovf}, {4'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_hold();
    apply(4'd3, 4'd4, 1'b1);
    checks++;
    if ({bus.zi, bus.co, bus.ovf, bus.out_valid} !== {4'd7, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hold_load got=%b want=%b", {bus.zi, bus.co, bus.ovf, bus.out_valid}, {4'd7, 1'b0, 1'b0, 1'b1});
    end
    apply(4'd9, 4'd9, 1'b0);
    checks++;
    if ({bus.zi, bus.co, bus.ovf, bus.out_valid} !== {4'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_idle got=%b want=%b", {bus.zi, bus.co, bus.ovf, bus.out_valid}, {4'd7, 1'b0, 1'b0, 1'b0});
    end
    apply(4'bxxxx, 4'bxxxx, 1'b0);
    checks++;
    if ({bus.zi, bus.co, bus.ovf, bus.out_valid} !== {4'd7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_x got=%b want=%b", {bus.zi, bus.co, bus.ovf, bus.out_valid}, {4'd7, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [4:0] want_sum;
        logic       want_ovf;
        int         sa;
        int         sb;
        int         ss;
        want_sum = 5'(a + b);
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        ss = sa + sb;
        want_ovf = (ss > 7 || ss < -8) ? 1'b1 : 1'b0;
        apply(4'(a), 4'(b), 1'b1);
        checks++;
        if ({bus.co, bus.zi, bus.ovf, bus.out_valid} !== {want_sum, want_ovf, 1'b1}) begin
          errors++;
          $display("FAIL exh %0d+%0d got co_zi=%0d ovf=%b v=%b want co_zi=%0d ovf=%b v=1",
                   a, b, {bus.co, bus.zi}, bus.ovf, bus.out_valid, want_sum, want_ovf);
        end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.xi       = 4'd0;
    bus.yi       = 4'd0;
    bus.in_valid = 1'b0;
    test_reset();
    test_sweep();
    test_wrap();
    test_overflow();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
